// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter: FSM state encoding,
// hold counter width, and the rotate-and-search priority pick.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // First set bit of r, searching upward from start and wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_4_to_1_w.sv
// W-bit wide 4:1 data selector used by the arbiter's registered output path.
module mux_4_to_1_w #(
    parameter int W = 1
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a registered W-bit mux with a hold limit.
// Define ARB_LOCK_EN to add the lock input that suppresses the MAX_HOLD release.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ARB_LOCK_EN
    input  logic         lock,
`endif
    input  logic [3:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] out,
    output logic         out_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_d;
    logic [3:0]       others;
    logic [1:0]       idle_pick, rel_pick;
    logic             lock_active;
    logic             release_now;
    logic [W-1:0]     mux_y;

`ifdef ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // The owner is always last in search order (ptr = owner+1), so masking it
    // out of req gives "next requester, owner excluded" directly.
    assign others      = req & ~onehot4(sel);
    assign idle_pick   = rr_pick(req, ptr_q);
    assign rel_pick    = rr_pick(others, ptr_q);
    assign release_now = !req[sel] || ((cnt_q == HOLD_LAST) && !lock_active);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    sel_d   = idle_pick;
                    gnt_d   = onehot4(idle_pick);
                    ptr_d   = idle_pick + 2'd1;
                    cnt_d   = '0;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    // Saturation only matters while lock holds the counter at its limit.
                    if (cnt_q != HOLD_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (others != 4'b0000) begin
                    sel_d = rel_pick;
                    gnt_d = onehot4(rel_pick);
                    ptr_d = rel_pick + 2'd1;
                    cnt_d = '0;
                end else if (req[sel]) begin
                    gnt_d = onehot4(sel);
                    ptr_d = sel + 2'd1;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    mux_4_to_1_w #(
        .W (W)
    ) u_mux (
        .sel (sel_d),
        .d0  (i0),
        .d1  (i1),
        .d2  (i2),
        .d3  (i3),
        .y   (mux_y)
    );

    // Output data follows the next-state select so it lines up with gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            out       <= mux_y;
            out_valid <= |gnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized
// traffic compared against an ownership-level reference model.
module tb_rr_mux_arbiter;

    localparam int W        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst;
    logic         lock;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] out;
    logic         out_valid;

    int errors;
    int checks;

    // Reference model: who owns the mux, for how many cycles, and where the next search starts.
    int           mOwner;
    int           mHeld;
    int           mPtr;
    int           mSel;
    logic [W-1:0] mOut;

    rr_mux_arbiter #(
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .i0        (d0),
        .i1        (d1),
        .i2        (d2),
        .i3        (d3),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] mGnt();
        return (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
    endfunction

    function automatic logic [W-1:0] dataOf(input int n);
        case (n)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, and settle for sampling.
    task automatic applyStimulus(input logic [3:0] r, input logic rs, input logic lk);
        int  nxt;
        bit  fresh;
        bit  done;
        int  n;
        req  = r;
        rst  = rs;
        lock = lk;
        @(posedge clk);
        if (rs) begin
            mOwner = -1;
            mHeld  = 0;
            mPtr   = 0;
            mSel   = 0;
            mOut   = '0;
        end else begin
            nxt   = -1;
            fresh = 1'b0;
            if (mOwner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    n = (mPtr + k) % 4;
                    if (nxt < 0 && r[n]) nxt = n;
                end
                fresh = (nxt >= 0);
            end else begin
                done = !r[mOwner] || (mHeld >= MAX_HOLD && !lk);
                if (!done) begin
                    nxt = mOwner;
                    if (mHeld < MAX_HOLD) mHeld++;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        n = (mPtr + k) % 4;
                        if (nxt < 0 && n != mOwner && r[n]) nxt = n;
                    end
                    if (nxt < 0 && r[mOwner]) nxt = mOwner;
                    fresh = (nxt >= 0);
                end
            end
            if (fresh) begin
                mHeld = 1;
                mPtr  = (nxt + 1) % 4;
            end
            mOwner = nxt;
            if (mOwner >= 0) mSel = mOwner;
            mOut = dataOf(mSel);
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        end
        checks++;
        if (sel !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel);
        end
        checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            errors++; $display("[TB] FAIL reset_out: got valid=%b out=%h expected valid=0 out=0", out_valid, out);
        end
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("[TB] FAIL reset_first_grant: got %b expected %b", gnt, 4'b0001);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
            applyStimulus(4'b1111, 1'b0, 1'b0);
            exp = 4'b0001 << ((k / 4) % 4);
            checks++;
            if (gnt !== exp) begin
                errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp);
            end
            checks++;
            if (out !== mOut || out_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL rr_out[%0d]: got %h/%b expected %h/1", k, out, out_valid, mOut);
            end
        end
    endtask

    task automatic test_early_release();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("[TB] FAIL early_owner2: got %b expected %b", gnt, 4'b0100);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1001, 1'b0, 1'b0);
            checks++;
            if (gnt !== 4'b1000) begin
                errors++; $display("[TB] FAIL early_next[%0d]: got %b expected %b", k, gnt, 4'b1000);
            end
        end
        applyStimulus(4'b1001, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("[TB] FAIL early_wrap: got %b expected %b", gnt, 4'b0001);
        end
    endtask

    task automatic test_datapath();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            errors++; $display("[TB] FAIL data_grant: got gnt=%b sel=%0d expected gnt=0100 sel=2", gnt, sel);
        end
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checks++;
        if (out !== 4'h3 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL data_out: got %h/%b expected 3/1", out, out_valid);
        end
    endtask

    task automatic test_regrant();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
            checks++;
            if (gnt !== 4'b0001 || out_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL regrant[%0d]: got %b/%b expected 0001/1", k, gnt, out_valid);
            end
        end
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL to_idle: got %b sel=%0d v=%b expected 0000 sel=0 v=0", gnt, sel, out_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(4'b1000, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++; $display("[TB] FAIL midrst_owner3: got %b expected %b", gnt, 4'b1000);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_drop: got %b sel=%0d v=%b expected 0000 sel=0 v=0", gnt, sel, out_valid);
        end
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("[TB] FAIL midrst_regrant: got %b expected %b", gnt, 4'b0010);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0011, 1'b0, 1'b1);
            checks++;
            if (gnt !== 4'b0001) begin
                errors++; $display("[TB] FAIL lock_hold[%0d]: got %b expected %b", k, gnt, 4'b0001);
            end
        end
        applyStimulus(4'b0011, 1'b0, 1'b0);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("[TB] FAIL lock_release: got %b expected %b", gnt, 4'b0010);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        logic       lk;
        r = 4'b0000;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(2) == 0) r = r ^ 4'($urandom);
            rs = ($urandom_range(39) == 0);
`ifdef ARB_LOCK_EN
            lk = ($urandom_range(3) == 0);
`else
            lk = 1'b0;
`endif
            d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
            applyStimulus(r, rs, lk);
            checks++;
            if (gnt !== mGnt() || sel !== 2'(mSel)) begin
                errors++; $display("[TB] FAIL rand_gnt[%0d]: got %b sel=%0d expected %b sel=%0d", k, gnt, sel, mGnt(), mSel);
            end
            checks++;
            if (out !== mOut || out_valid !== (mOwner >= 0)) begin
                errors++; $display("[TB] FAIL rand_out[%0d]: got %h/%b expected %h/%b", k, out, out_valid, mOut, (mOwner >= 0));
            end
            checks++;
            if ($countones(gnt) > 1) begin
                errors++; $display("[TB] FAIL rand_onehot[%0d]: got %b expected at most one bit", k, gnt);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        lock   = 1'b0;
        req    = 4'b0000;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        mOwner = -1; mHeld = 0; mPtr = 0; mSel = 0; mOut = '0;
        test_reset();
        test_round_robin();
        test_early_release();
        test_datapath();
        test_regrant();
        test_reset_mid_grant();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
